key_conditioner: RTL and testbench



---
 rtl/key_cond_pkg.sv | 24 ++
 rtl/key_conditioner_tick_gen.sv | 39 +++
 rtl/key_conditioner.sv | 151 +++++++++++++++
 tb/tb_key_conditioner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// ============================================================================
// Module   : key_cond_pkg
// Brief    : Shared debounce FSM state encoding and counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_cond_pkg;

    typedef enum logic [1:0] {
        S_LO     = 2'd0,
        S_CHK_HI = 2'd1,
        S_HI     = 2'd2,
        S_CHK_LO = 2'd3
    } state_t;

    // Bits needed to count 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_conditioner_tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Brief    : Free-running divider producing a registered one-cycle tick
//            every TICK_DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen
    import key_cond_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             C_CW   = cnt_width(TICK_DIV);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(TICK_DIV - 1);

    logic [C_CW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= w_wrap;
            r_cnt <= w_wrap ? '0 : r_cnt + C_CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// ============================================================================
// Module   : key_conditioner
// Brief    : Synchronises and debounces a raw push-button into a clean key
//            level with edge strobes. Optional key_fall output is enabled by
//            defining KEY_CONDITIONER_FALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int DB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic pulse_p,
    output logic key,
    output logic key_rise
`ifdef KEY_CONDITIONER_FALL_EN
    ,
    output logic key_fall
`endif
);

    localparam int               C_CNT_W    = cnt_width(DB_SAMPLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DB_SAMPLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    logic               r_sync1;
    logic               r_key_s;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               w_acc_hi;
    logic               w_acc_lo;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (pulse_p)
    );

    // Decisions are taken only on tick cycles; r_cnt holds samples already seen.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_hi    = 1'b0;
        w_acc_lo    = 1'b0;
        if (pulse_p) begin
            case (r_state)
                S_LO: begin
                    if (r_key_s) begin
                        if (DB_SAMPLES == 1) begin
                            w_acc_hi    = 1'b1;
                            w_state_nxt = S_HI;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_CHK_HI;
                            w_cnt_nxt   = C_CNT_ONE;
                        end
                    end
                end
                S_CHK_HI: begin
                    if (r_key_s) begin
                        if (r_cnt == C_CNT_LAST) begin
                            w_acc_hi    = 1'b1;
                            w_state_nxt = S_HI;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + C_CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = S_LO;
                        w_cnt_nxt   = '0;
                    end
                end
                S_HI: begin
                    if (!r_key_s) begin
                        if (DB_SAMPLES == 1) begin
                            w_acc_lo    = 1'b1;
                            w_state_nxt = S_LO;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_CHK_LO;
                            w_cnt_nxt   = C_CNT_ONE;
                        end
                    end
                end
                S_CHK_LO: begin
                    if (!r_key_s) begin
                        if (r_cnt == C_CNT_LAST) begin
                            w_acc_lo    = 1'b1;
                            w_state_nxt = S_LO;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + C_CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = S_HI;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_LO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_key_s  <= 1'b0;
            r_state  <= S_LO;
            r_cnt    <= '0;
            key      <= 1'b0;
            key_rise <= 1'b0;
        end else begin
            r_sync1  <= key_raw;
            r_key_s  <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            key_rise <= w_acc_hi;
            if (w_acc_hi) begin
                key <= 1'b1;
            end else if (w_acc_lo) begin
                key <= 1'b0;
            end
        end
    end

`ifdef KEY_CONDITIONER_FALL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            key_fall <= 1'b0;
        end else begin
            key_fall <= w_acc_lo;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ============================================================================
// Module   : tb_key_conditioner
// Brief    : Directed self-checking bench; DUT a uses TICK_DIV=4/DB_SAMPLES=3,
//            DUT b the degenerate TICK_DIV=1/DB_SAMPLES=1 configuration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic key_raw_a, pulse_a, key_a, rise_a;
    logic key_raw_b, pulse_b, key_b, rise_b;
    logic fall_a, fall_b;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

`ifndef KEY_CONDITIONER_FALL_EN
    assign fall_a = 1'b0;
    assign fall_b = 1'b0;
`endif

    key_conditioner #(.TICK_DIV(4), .DB_SAMPLES(3)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_raw_a),
        .pulse_p  (pulse_a),
        .key      (key_a),
        .key_rise (rise_a)
`ifdef KEY_CONDITIONER_FALL_EN
        ,
        .key_fall (fall_a)
`endif
    );

    key_conditioner #(.TICK_DIV(1), .DB_SAMPLES(1)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_raw_b),
        .pulse_p  (pulse_b),
        .key      (key_b),
        .key_rise (rise_b)
`ifdef KEY_CONDITIONER_FALL_EN
        ,
        .key_fall (fall_b)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Returns positioned #1 into cycle 0 (rst low, reset values visible).
    task automatic release_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_p;
        key_raw_a = 1'b0;
        release_rst();
        for (int c = 0; c <= 17; c++) begin
            exp_p = (c != 0) && (c % 4 == 0);
            checks += 3;
            if (pulse_a !== exp_p) begin
                errors++; $display("FAIL reset_pulse c=%0d got=%b exp=%b", c, pulse_a, exp_p);
            end
            if (key_a !== 1'b0) begin
                errors++; $display("FAIL reset_key c=%0d got=%b exp=0", c, key_a);
            end
            if (rise_a !== 1'b0) begin
                errors++; $display("FAIL reset_rise c=%0d got=%b exp=0", c, rise_a);
            end
            next_cycle();
        end
        release_rst();
        for (int c = 0; c <= 9; c++) begin
            if (c == 9) release_rst();
            else next_cycle();
        end
        for (int c = 0; c <= 8; c++) begin
            exp_p = (c == 4) || (c == 8);
            checks++;
            if (pulse_a !== exp_p) begin
                errors++; $display("FAIL rerst_pulse c=%0d got=%b exp=%b", c, pulse_a, exp_p);
            end
            next_cycle();
        end
    endtask

    task automatic test_press();
        release_rst();
        key_raw_a = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            checks += 2;
            if (key_a !== (c >= 13)) begin
                errors++; $display("FAIL press_key c=%0d got=%b exp=%b", c, key_a, c >= 13);
            end
            if (rise_a !== (c == 13)) begin
                errors++; $display("FAIL press_rise c=%0d got=%b exp=%b", c, rise_a, c == 13);
            end
            next_cycle();
        end
    endtask

    task automatic test_bounce();
        release_rst();
        for (int c = 0; c <= 24; c++) begin
            key_raw_a = !((c == 6) || (c == 7));
            checks += 2;
            if (key_a !== (c >= 21)) begin
                errors++; $display("FAIL bounce_key c=%0d got=%b exp=%b", c, key_a, c >= 21);
            end
            if (rise_a !== (c == 21)) begin
                errors++; $display("FAIL bounce_rise c=%0d got=%b exp=%b", c, rise_a, c == 21);
            end
            next_cycle();
        end
    endtask

    task automatic test_release();
        logic exp_k;
        release_rst();
        for (int c = 0; c <= 28; c++) begin
            key_raw_a = (c < 13);
            exp_k = (c >= 13) && (c < 25);
            checks += 2;
            if (key_a !== exp_k) begin
                errors++; $display("FAIL release_key c=%0d got=%b exp=%b", c, key_a, exp_k);
            end
            if (rise_a !== (c == 13)) begin
                errors++; $display("FAIL release_rise c=%0d got=%b exp=%b", c, rise_a, c == 13);
            end
`ifdef KEY_CONDITIONER_FALL_EN
            checks++;
            if (fall_a !== (c == 25)) begin
                errors++; $display("FAIL release_fall c=%0d got=%b exp=%b", c, fall_a, c == 25);
            end
`endif
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_check();
        release_rst();
        key_raw_a = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c == 9) release_rst();
            else next_cycle();
        end
        checks += 3;
        if (pulse_a !== 1'b0) begin
            errors++; $display("FAIL midrst_pulse got=%b exp=0", pulse_a);
        end
        if (key_a !== 1'b0) begin
            errors++; $display("FAIL midrst_key got=%b exp=0", key_a);
        end
        if (rise_a !== 1'b0) begin
            errors++; $display("FAIL midrst_rise got=%b exp=0", rise_a);
        end
        for (int c = 0; c <= 15; c++) begin
            checks += 2;
            if (key_a !== (c >= 13)) begin
                errors++; $display("FAIL midrst_key c=%0d got=%b exp=%b", c, key_a, c >= 13);
            end
            if (rise_a !== (c == 13)) begin
                errors++; $display("FAIL midrst_rise c=%0d got=%b exp=%b", c, rise_a, c == 13);
            end
            next_cycle();
        end
    endtask

    task automatic test_degenerate();
        logic [15:0] pat;
        logic        hist [0:21];
        logic        exp_k, prev_k, exp_r, exp_f;
        pat = 16'b0011_1000_1011_0010;
        key_raw_a = 1'b0;
        key_raw_b = 1'b0;
        release_rst();
        for (int c = 0; c <= 21; c++) begin
            key_raw_b = (c < 16) ? pat[c] : 1'b0;
            hist[c]   = key_raw_b;
            exp_k  = (c >= 3) ? hist[c-3] : 1'b0;
            prev_k = (c >= 4) ? hist[c-4] : 1'b0;
            exp_r  = exp_k & ~prev_k;
            exp_f  = ~exp_k & prev_k;
            checks += 3;
            if (pulse_b !== (c >= 1)) begin
                errors++; $display("FAIL degen_pulse c=%0d got=%b exp=%b", c, pulse_b, c >= 1);
            end
            if (key_b !== exp_k) begin
                errors++; $display("FAIL degen_key c=%0d got=%b exp=%b", c, key_b, exp_k);
            end
            if (rise_b !== exp_r) begin
                errors++; $display("FAIL degen_rise c=%0d got=%b exp=%b", c, rise_b, exp_r);
            end
`ifdef KEY_CONDITIONER_FALL_EN
            checks++;
            if (fall_b !== exp_f) begin
                errors++; $display("FAIL degen_fall c=%0d got=%b exp=%b", c, fall_b, exp_f);
            end
`endif
            next_cycle();
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_raw_a = 1'b0;
        key_raw_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_reset_mid_check();
        test_degenerate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
